multicycle_ctrl_fsm: RTL

- Control FSM for the multicycle RV32I subset core (lw, sw, R-type, I-type ALU, beq, jal).
- Sequences the shared ALU, memory port, instruction register and PC.
- Drives imm_src to the immediate extender.
- Adds a memory-ready handshake with a timeout watchdog, plus sticky illegal and bus-error halt flags.

---
 rtl/multicycle_ctrl_fsm.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl_fsm.sv
// Control FSM for the multicycle RV32I-subset core with a memory-ready watchdog
// and sticky halt flags. Optional retired-instruction counter: define RETIRE_CNT_EN.
module multicycle_ctrl_fsm #(
  parameter int MEM_TIMEOUT = 15,
  parameter int TO_W        = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_control,
  output logic [1:0] imm_src,
  output logic       reg_write,
  output logic [3:0] state,
  output logic       illegal,
  output logic       bus_err
`ifdef RETIRE_CNT_EN
  ,output logic [31:0] retired
`endif
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECUTEI = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10,
    S_HALT     = 4'd15
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [TO_W-1:0] TIMEOUT = TO_W'(MEM_TIMEOUT);

  state_t          state_q, state_d;
  logic [TO_W-1:0] wait_cnt;
  logic            illegal_q, bus_err_q;
  logic            set_illegal, set_bus_err;
  logic            pc_update, branch;
  logic            ir_write_raw, mem_write_raw, reg_write_raw;
  logic [1:0]      alu_op;
  logic            funct3_ok;
  logic            mem_state;
  logic            timeout;

  assign funct3_ok = (funct3 == 3'b000) || (funct3 == 3'b010) ||
                     (funct3 == 3'b110) || (funct3 == 3'b111);
  assign mem_state = (state_q == S_FETCH) || (state_q == S_MEMREAD) ||
                     (state_q == S_MEMWRITE);
  // A ready in the same cycle as the limit wins: timeout requires mem_ready=0.
  assign timeout   = mem_state && !mem_ready && (wait_cnt == TIMEOUT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      wait_cnt  <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (set_illegal) illegal_q <= 1'b1;
      if (set_bus_err) bus_err_q <= 1'b1;
      // Staying in a memory state means a wait cycle; any move restarts the count.
      if (mem_state && (state_d == state_q)) wait_cnt <= wait_cnt + TO_W'(1);
      else                                   wait_cnt <= '0;
    end
  end

  always_comb begin
    state_d       = state_q;
    set_illegal   = 1'b0;
    set_bus_err   = 1'b0;
    pc_update     = 1'b0;
    branch        = 1'b0;
    ir_write_raw  = 1'b0;
    mem_write_raw = 1'b0;
    reg_write_raw = 1'b0;
    adr_src       = 1'b0;
    result_src    = 2'b00;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    case (state_q)
      S_FETCH: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        if (mem_ready) begin
          ir_write_raw = 1'b1;
          pc_update    = 1'b1;
          state_d      = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = funct3_ok ? S_EXECUTER : S_HALT;
          OP_I:         state_d = funct3_ok ? S_EXECUTEI : S_HALT;
          OP_JAL:       state_d = S_JAL;
          OP_BEQ:       state_d = (funct3 == 3'b000) ? S_BEQ : S_HALT;
          default:      state_d = S_HALT;
        endcase
        set_illegal = (state_d == S_HALT);
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src    = 2'b01;
        reg_write_raw = 1'b1;
        state_d       = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src       = 1'b1;
        mem_write_raw = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXECUTER: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_EXECUTEI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_raw = 1'b1;
        state_d       = S_FETCH;
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_update = 1'b1;
        state_d   = S_ALUWB;
      end
      S_BEQ: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        branch    = 1'b1;
        state_d   = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_HALT;
    endcase
    if (timeout) begin
      state_d     = S_HALT;
      set_bus_err = 1'b1;
    end
  end

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      2'b01: alu_control = ALU_SUB;
      2'b10: begin
        case (funct3)
          3'b000:  alu_control = (op[5] & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

  always_comb begin
    imm_src = 2'b00;
    case (op)
      OP_SW:   imm_src = 2'b01;
      OP_BEQ:  imm_src = 2'b10;
      OP_JAL:  imm_src = 2'b11;
      default: imm_src = 2'b00;
    endcase
  end

  // rst_n gates the strobes so an in-flight access is dropped the instant reset asserts.
  assign pc_write  = rst_n & (pc_update | (branch & zero));
  assign ir_write  = rst_n & ir_write_raw;
  assign mem_write = rst_n & mem_write_raw;
  assign reg_write = rst_n & reg_write_raw;
  assign state     = state_q;
  assign illegal   = illegal_q;
  assign bus_err   = bus_err_q;

`ifdef RETIRE_CNT_EN
  logic [31:0] retired_q;
  logic        retire_evt;

  assign retire_evt = (state_d == S_FETCH) &&
                      ((state_q == S_MEMWB) || (state_q == S_MEMWRITE) ||
                       (state_q == S_ALUWB) || (state_q == S_BEQ));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          retired_q <= '0;
    else if (retire_evt) retired_q <= retired_q + 32'd1;
  end

  assign retired = retired_q;
`endif

endmodule
